// File: rtl/carregador_digitos_pkg.sv
`default_nettype none
// ============================================================================
// Module      : carregador_digitos_pkg
// Description : Shared constants and state encoding for the digit loader.
// Revision    : 1.0 - initial release
// ============================================================================
package carregador_digitos_pkg;

  // Number of digit slots feeding the separator
  localparam int N_DIG = 6;

  // Default digit width
  localparam int DATA_W_DEF = 4;

  // Write pointer width (holds 0..N_DIG)
  localparam int PTR_W = 3;

  // Loader states
  localparam logic [1:0] VAZIO  = 2'd0;
  localparam logic [1:0] ENCHER = 2'd1;
  localparam logic [1:0] CHEIO  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/carregador_digitos_detetor_flanco.sv
`default_nettype none
// ============================================================================
// Module      : detetor_flanco
// Description : Registered rising-edge detector; one pulse per 0->1 level.
// Revision    : 1.0 - initial release
// ============================================================================
module detetor_flanco (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_pulse
);

  logic r_q;

  // Sample the level every cycle; reset to 0 so a level held high out of
  // reset yields exactly one pulse on the first clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q <= 1'b0;
    else       r_q <= i_sig;
  end

  assign o_pulse = i_sig & ~r_q;

endmodule
`default_nettype wire

// File: rtl/carregador_digitos.sv
`default_nettype none
// ============================================================================
// Module      : carregador_digitos
// Description : Collects six digits one at a time into parallel slots, with
//               edge-triggered load/rotate, write pointer, full flag and a
//               one-cycle "contents changed" strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module carregador_digitos
  import carregador_digitos_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  input  logic              rot,
  input  logic              clear,
  output logic [DATA_W-1:0] m0,
  output logic [DATA_W-1:0] m1,
  output logic [DATA_W-1:0] m2,
  output logic [DATA_W-1:0] m3,
  output logic [DATA_W-1:0] m4,
  output logic [DATA_W-1:0] m5,
  output logic [PTR_W-1:0]  ptr,
  output logic              full,
  output logic              novo
);

  localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(N_DIG - 1);

  logic w_load_ev;
  logic w_rot_ev;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_slot     [N_DIG];
  logic [DATA_W-1:0] w_slot_nxt [N_DIG];
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic              r_full;
  logic              r_novo;
  logic              w_novo_nxt;
  logic              w_any_nz;

  detetor_flanco u_flanco_load (
    .clk     (clk),
    .reset   (reset),
    .i_sig   (load),
    .o_pulse (w_load_ev)
  );

  detetor_flanco u_flanco_rot (
    .clk     (clk),
    .reset   (reset),
    .i_sig   (rot),
    .o_pulse (w_rot_ev)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= VAZIO;
    else       r_state <= w_state_nxt;
  end

  // Next state: clear wins, then a load that still has room
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = VAZIO;
    end else if (w_load_ev && (r_state != CHEIO)) begin
      w_state_nxt = (r_ptr == c_ptr_last) ? CHEIO : ENCHER;
    end
  end

  // Datapath next values: clear > load (not full) > rotate (full only)
  always_comb begin
    w_any_nz = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      w_slot_nxt[i] = r_slot[i];
      w_any_nz      = w_any_nz | (|r_slot[i]);
    end
    w_ptr_nxt  = r_ptr;
    w_novo_nxt = 1'b0;
    if (clear) begin
      for (int i = 0; i < N_DIG; i++) w_slot_nxt[i] = '0;
      w_ptr_nxt  = '0;
      w_novo_nxt = w_any_nz;
    end else if (w_load_ev && (r_state != CHEIO)) begin
      for (int i = 0; i < N_DIG; i++) begin
        if (r_ptr == PTR_W'(i)) w_slot_nxt[i] = din;
      end
      w_ptr_nxt  = r_ptr + PTR_W'(1);
      w_novo_nxt = 1'b1;
    end else if (w_rot_ev && (r_state == CHEIO)) begin
      for (int i = 0; i < N_DIG; i++) begin
        w_slot_nxt[i] = r_slot[(i + 1) % N_DIG];
      end
      w_novo_nxt = 1'b1;
    end
  end

  // Slot, pointer, full flag and strobe registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_DIG; i++) r_slot[i] <= '0;
      r_ptr  <= '0;
      r_full <= 1'b0;
      r_novo <= 1'b0;
    end else begin
      for (int i = 0; i < N_DIG; i++) r_slot[i] <= w_slot_nxt[i];
      r_ptr  <= w_ptr_nxt;
      r_full <= (w_state_nxt == CHEIO);
      r_novo <= w_novo_nxt;
    end
  end

  assign m0   = r_slot[0];
  assign m1   = r_slot[1];
  assign m2   = r_slot[2];
  assign m3   = r_slot[3];
  assign m4   = r_slot[4];
  assign m5   = r_slot[5];
  assign ptr  = r_ptr;
  assign full = r_full;
  assign novo = r_novo;

endmodule
`default_nettype wire

// File: tb/tb_carregador_digitos.sv
`default_nettype none
// ============================================================================
// Module      : tb_carregador_digitos
// Description : Directed, table-driven self-checking bench for the loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_carregador_digitos;

  logic       clk;
  logic       reset;
  logic [3:0] din;
  logic       load;
  logic       rot;
  logic       clear;
  logic [3:0] m0, m1, m2, m3, m4, m5;
  logic [2:0] ptr;
  logic       full;
  logic       novo;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        ld;
    logic        rt;
    logic        cl;
    logic [3:0]  d;
    logic [23:0] exp_m;   // {m0,m1,m2,m3,m4,m5}
    logic [2:0]  exp_ptr;
    logic        exp_full;
    logic        exp_novo;
  } vec_t;

  vec_t vecs[$];

  carregador_digitos #(.DATA_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .load  (load),
    .rot   (rot),
    .clear (clear),
    .m0    (m0),
    .m1    (m1),
    .m2    (m2),
    .m3    (m3),
    .m4    (m4),
    .m5    (m5),
    .ptr   (ptr),
    .full  (full),
    .novo  (novo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic ld, input logic rt, input logic cl,
                              input logic [3:0] d, input logic [23:0] em,
                              input logic [2:0] ep, input logic ef,
                              input logic en);
    vec_t v;
    v.ld = ld; v.rt = rt; v.cl = cl; v.d = d;
    v.exp_m = em; v.exp_ptr = ep; v.exp_full = ef; v.exp_novo = en;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [23:0] em,
                           input logic [2:0] ep, input logic ef, input logic en);
    check({tag, " slots"}, {8'd0, m0, m1, m2, m3, m4, m5}, {8'd0, em});
    check({tag, " ptr"},   {29'd0, ptr}, {29'd0, ep});
    check({tag, " full"},  {31'd0, full}, {31'd0, ef});
    check({tag, " novo"},  {31'd0, novo}, {31'd0, en});
  endtask

  // Drive one load pulse (high one cycle, low one cycle)
  task automatic pulse_load(input logic [3:0] d);
    load = 1'b1; din = d;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; load = 1'b1; rot = 1'b0; clear = 1'b0; din = 4'd5;

    // ---- Reset with load held high ----
    @(posedge clk); @(posedge clk); #1;
    check_all("reset", 24'h000000, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_all("held_load_first", 24'h500000, 3'd1, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      check_all("held_load_hold", 24'h500000, 3'd1, 1'b0, 1'b0);
    end
    load = 1'b0;

    // Clean restart via mid-cycle async reset
    #2 reset = 1'b1;
    #1 reset = 1'b0;

    // ---- Vector table ----
    //   ld rt cl din  slots      ptr  full novo
    add(1, 0, 0, 1, 24'h100000, 1, 0, 1); add(0, 0, 0, 0, 24'h100000, 1, 0, 0);
    add(1, 0, 0, 2, 24'h120000, 2, 0, 1); add(0, 0, 0, 0, 24'h120000, 2, 0, 0);
    add(1, 0, 0, 3, 24'h123000, 3, 0, 1); add(0, 0, 0, 0, 24'h123000, 3, 0, 0);
    add(1, 0, 0, 4, 24'h123400, 4, 0, 1); add(0, 0, 0, 0, 24'h123400, 4, 0, 0);
    add(1, 0, 0, 5, 24'h123450, 5, 0, 1); add(0, 0, 0, 0, 24'h123450, 5, 0, 0);
    add(1, 0, 0, 6, 24'h123456, 6, 1, 1); add(0, 0, 0, 0, 24'h123456, 6, 1, 0);
    // seventh load ignored when full
    add(1, 0, 0, 9, 24'h123456, 6, 1, 0); add(0, 0, 0, 0, 24'h123456, 6, 1, 0);
    // rotate once, then six more back to the same pattern
    add(0, 1, 0, 0, 24'h234561, 6, 1, 1); add(0, 0, 0, 0, 24'h234561, 6, 1, 0);
    add(0, 1, 0, 0, 24'h345612, 6, 1, 1); add(0, 0, 0, 0, 24'h345612, 6, 1, 0);
    add(0, 1, 0, 0, 24'h456123, 6, 1, 1); add(0, 0, 0, 0, 24'h456123, 6, 1, 0);
    add(0, 1, 0, 0, 24'h561234, 6, 1, 1); add(0, 0, 0, 0, 24'h561234, 6, 1, 0);
    add(0, 1, 0, 0, 24'h612345, 6, 1, 1); add(0, 0, 0, 0, 24'h612345, 6, 1, 0);
    add(0, 1, 0, 0, 24'h123456, 6, 1, 1); add(0, 0, 0, 0, 24'h123456, 6, 1, 0);
    add(0, 1, 0, 0, 24'h234561, 6, 1, 1); add(0, 0, 0, 0, 24'h234561, 6, 1, 0);
    // load+rot together when full: rotate wins
    add(1, 1, 0, 9, 24'h345612, 6, 1, 1); add(0, 0, 0, 0, 24'h345612, 6, 1, 0);
    // clear with nonzero slots, then idle
    add(0, 0, 1, 0, 24'h000000, 0, 0, 1); add(0, 0, 0, 0, 24'h000000, 0, 0, 0);
    // three loads, ignored rotate, then load+rot together
    add(1, 0, 0, 1, 24'h100000, 1, 0, 1); add(0, 0, 0, 0, 24'h100000, 1, 0, 0);
    add(1, 0, 0, 2, 24'h120000, 2, 0, 1); add(0, 0, 0, 0, 24'h120000, 2, 0, 0);
    add(1, 0, 0, 3, 24'h123000, 3, 0, 1); add(0, 0, 0, 0, 24'h123000, 3, 0, 0);
    add(0, 1, 0, 0, 24'h123000, 3, 0, 0); add(0, 0, 0, 0, 24'h123000, 3, 0, 0);
    add(1, 1, 0, 7, 24'h123700, 4, 0, 1); add(0, 0, 0, 0, 24'h123700, 4, 0, 0);
    // clear with a load edge, then a second clear on empty slots
    add(1, 0, 1, 8, 24'h000000, 0, 0, 1); add(0, 0, 1, 0, 24'h000000, 0, 0, 0);
    add(0, 0, 0, 0, 24'h000000, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      load = vecs[i].ld; rot = vecs[i].rt; clear = vecs[i].cl; din = vecs[i].d;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_m, vecs[i].exp_ptr,
                vecs[i].exp_full, vecs[i].exp_novo);
    end
    load = 1'b0; rot = 1'b0; clear = 1'b0;

    // ---- Async reset while full ----
    pulse_load(4'hA); pulse_load(4'hB); pulse_load(4'hC);
    pulse_load(4'hD); pulse_load(4'hE); pulse_load(4'hF);
    check_all("refill", 24'hABCDEF, 3'd6, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_all("async_reset", 24'h000000, 3'd0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    load = 1'b1; din = 4'd4;
    @(posedge clk); #1;
    check_all("resume", 24'h400000, 3'd1, 1'b0, 1'b1);
    load = 1'b0;
    @(posedge clk); #1;
    check_all("resume_idle", 24'h400000, 3'd1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/carregador_digitos.md
Name: carregador_digitos

Overview:
- Upstream stage of the digit separator. Collects six 4-bit digits entered one at a time on `din` and holds them in six parallel registers `m0`..`m5`, which drive the separator inputs directly.
- Adds edge-detected load and rotate commands, a write pointer, a full flag and a one-cycle update strobe, so the downstream stages know when the digit set changed.

Parameters:
- DATA_W, 4, width of each digit slot and of din. Slot count is fixed at 6.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_W  digit to store on the next load event.
- load  input  1  load command, level input; only its rising edge acts.
- rot  input  1  rotate command, level input; only its rising edge acts.
- clear  input  1  synchronous clear, level-sensitive.
- m0..m5  output  DATA_W each  registered digit slots; m0 is the first digit entered.
- ptr  output  3  next slot to write, 0..6.
- full  output  1  high when all six slots are written.
- novo  output  1  one-cycle pulse in the cycle after any slot contents change.

Behaviour:
- Reset, asynchronous:
  - m0..m5 = 0, ptr = 0, full = 0, novo = 0.
  - Edge registers load_q = 0 and rot_q = 0.
  - State = VAZIO.
- Edge detection:
  - load_ev = load & ~load_q; rot_ev = rot & ~rot_q.
  - load_q and rot_q are sampled every cycle.
  - A level held high from reset release produces exactly one event, on the first clock.
- States:
  - VAZIO: ptr = 0, full = 0.
  - ENCHER: ptr = 1..5.
  - CHEIO: ptr = 6, full = 1.
- Priority per cycle: clear > load_ev > rot_ev.
- clear = 1:
  - All slots = 0, ptr = 0, state = VAZIO.
  - novo = 1 next cycle only if some slot was nonzero; otherwise novo = 0.
  - Events occurring in the same cycle are discarded.
- load_ev in VAZIO or ENCHER:
  - Slot[ptr] = din, ptr = ptr + 1.
  - Transition to ENCHER, or to CHEIO when ptr becomes 6.
  - novo = 1 next cycle.
- load_ev in CHEIO: ignored; no slot, ptr or novo change.
- rot_ev in CHEIO:
  - Circular left rotate: m0 <= m1, m1 <= m2, ..., m4 <= m5, m5 <= m0.
  - novo = 1 next cycle; ptr and full unchanged.
- rot_ev in VAZIO or ENCHER: ignored.
- Simultaneous load_ev and rot_ev:
  - In ENCHER, load is executed and rot is dropped.
  - In CHEIO, load is ignored and rot is executed.
- Latency: an event sampled at edge k is visible on m*/ptr/full after edge k, and novo is high for the cycle between edges k and k+1.
- ptr never exceeds 6 and never wraps; only clear or reset returns it to 0.
- full is a registered copy of (state == CHEIO), with no combinational path from inputs.
- Reset asserted mid-sequence aborts immediately; no partial write survives.
- din is sampled only on a load_ev cycle and is otherwise don't-care.

Decomposition:
- Shared package holds:
  - Slot count constant N_DIG = 6.
  - State encoding VAZIO = 2'd0, ENCHER = 2'd1, CHEIO = 2'd2.
  - DATA_W default.
- One natural sub-module: detetor_flanco, a registered rising-edge detector with async active-high reset, instantiated twice (load, rot).
- Slot storage, pointer and state machine stay in the top module.

Test Plan:
- Reset with load = 1 held, then keep it high 10 cycles → exactly one write: m0 = din, ptr = 1, novo high for one cycle only.
- Six load pulses with din = 1, 2, 3, 4, 5, 6 → m0..m5 = 1..6, ptr = 6, full = 1 on the cycle after the sixth edge. A seventh pulse with din = 9 → no change, novo stays 0.
- From full 1..6, one rot pulse → m0..m5 = 2, 3, 4, 5, 6, 1. Six further rot pulses → back to the same values, one novo pulse per rotate.
- After three loads (ptr = 3):
  - rot pulse → ignored.
  - load and rot rising in the same cycle with din = 7 → m3 = 7, ptr = 4, slots 0..2 unchanged.
- clear asserted together with a load edge while ptr = 4 → all slots 0, ptr = 0, full = 0, no write of din, novo = 1 once. A second clear → novo stays 0.
- reset pulsed asynchronously between clock edges in CHEIO → outputs 0 immediately without a clock edge. After release, loading resumes at m0.
